// File: rtl/move_tick_gen.sv
// Move-tick generator: turns the selected move period into a one-cycle move_tick and sequences run/pause/over.
// Optional feature: define MOVE_BOOST_EN to let the boost input halve the period at each reload.
module move_tick_gen #(
    parameter int unsigned MIN_PERIOD = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [40:0]      speed,
    input  logic             start,
    input  logic             pause_btn,
    input  logic             game_over,
    input  logic             boost,
    output logic             move_tick,
    output logic             running,
    output logic             paused,
    output logic [40:0]      period_active,
    output logic [CNT_W-1:0] tick_count
);

    localparam int unsigned PER_W = 41;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PER_W-1:0]   cnt_q, cnt_d;
    logic [PER_W-1:0]   period_active_q, period_active_d;
    logic [CNT_W-1:0]   tick_count_q, tick_count_d;
    logic               move_tick_q, move_tick_d;
    logic               running_q, running_d;
    logic               paused_q, paused_d;
    logic               start_q, pause_q;

    logic               start_edge_c;
    logic               pause_edge_c;
    logic               last_c;
    logic [PER_W-1:0]   req_c;
    logic [PER_W-1:0]   eff_c;
    logic [CNT_W-1:0]   tick_inc_c;

    // Requested period, optionally halved by boost, clamped to the legal minimum.
`ifdef MOVE_BOOST_EN
    always_comb begin
        req_c = boost ? (speed >> 1) : speed;
    end
`else
    logic unused_boost;
    assign unused_boost = boost;
    always_comb begin
        req_c = speed;
    end
`endif

    always_comb begin
        eff_c = (req_c < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : req_c;
    end

    assign start_edge_c = start & ~start_q;
    assign pause_edge_c = pause_btn & ~pause_q;
    // period_active never drops below MIN_PERIOD, so the subtraction cannot wrap.
    assign last_c       = (cnt_q == (period_active_q - PER_W'(1)));
    assign tick_inc_c   = (&tick_count_q) ? tick_count_q : (tick_count_q + CNT_W'(1));

    // Next-state and next-output logic; game_over outranks start, start outranks pause.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        period_active_d = period_active_q;
        tick_count_d    = tick_count_q;
        move_tick_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (start_edge_c) begin
                    state_d         = ST_RUN;
                    period_active_d = eff_c;
                    cnt_d           = '0;
                    tick_count_d    = '0;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else begin
                    // A tick coinciding with a pause edge is still emitted before pausing.
                    if (last_c) begin
                        move_tick_d     = 1'b1;
                        cnt_d           = '0;
                        period_active_d = eff_c;
                        tick_count_d    = tick_inc_c;
                    end else if (!pause_edge_c) begin
                        cnt_d = cnt_q + PER_W'(1);
                    end
                    if (pause_edge_c) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (pause_edge_c) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            period_active_q <= PER_W'(MIN_PERIOD);
            tick_count_q    <= '0;
            move_tick_q     <= 1'b0;
            running_q       <= 1'b0;
            paused_q        <= 1'b0;
            start_q         <= 1'b0;
            pause_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            period_active_q <= period_active_d;
            tick_count_q    <= tick_count_d;
            move_tick_q     <= move_tick_d;
            running_q       <= running_d;
            paused_q        <= paused_d;
            start_q         <= start;
            pause_q         <= pause_btn;
        end
    end

    assign move_tick     = move_tick_q;
    assign running       = running_q;
    assign paused        = paused_q;
    assign period_active = period_active_q;
    assign tick_count    = tick_count_q;

endmodule
